// File: rtl/pixl_ap_pkg.sv
// Purpose: shared constants and FSM state type for the A8 memory-aperture register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pixl_ap_pkg;

    // A8 page that hosts the aperture descriptors ($D6xx)
    localparam logic [7:0] PAGE_MEM_AP = 8'hD6;

    // Bytes per aperture descriptor
    localparam int AP_BYTES = 16;

    // Byte offsets within one descriptor (multi-byte fields little-endian)
    localparam logic [3:0] AP_OFS_BASE   = 4'h0;  // 0-3 SDRAM base
    localparam logic [3:0] AP_OFS_START  = 4'h4;  // first page
    localparam logic [3:0] AP_OFS_COUNT  = 4'h5;  // number of pages
    localparam logic [3:0] AP_OFS_STRIDE = 4'h6;
    localparam logic [3:0] AP_OFS_X      = 4'h7;  // 7-8
    localparam logic [3:0] AP_OFS_Y      = 4'h9;  // 9-A
    localparam logic [3:0] AP_OFS_W      = 4'hB;  // B-C
    localparam logic [3:0] AP_OFS_H      = 4'hD;  // D-E
    localparam logic [3:0] AP_OFS_CTRL   = 4'hF;  // bit0 enable, 7:1 stored only

    // page_map rebuild sequencer
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } ap_state_t;

endpackage

// File: rtl/ap_range_mask.sv
// Purpose: page range [start, start+count) -> 256-bit page mask, end clamped at 256 (no wrap).
// Latency: combinational.
// Backpressure: none.
module ap_range_mask (
    input  logic [7:0]   start,
    input  logic [7:0]   count,
    output logic [255:0] mask
);

    logic [8:0] end_sum;
    logic [8:0] end_clamp;

    // Two-shift mask: ones from start upward, minus ones from end upward
    always_comb begin
        end_sum   = {1'b0, start} + {1'b0, count};
        end_clamp = (end_sum > 9'd256) ? 9'd256 : end_sum;
        mask      = ({256{1'b1}} << start) & ~({256{1'b1}} << end_clamp);
    end

endmodule

// File: rtl/a8_aperture_regs.sv
// Purpose: $D6xx aperture descriptor registers and atomic page_map rebuild (A8_AP_READBACK_EN enables readback).
// Latency: byte write 1 cycle; page_map NUM_AP+2 cycles after a trigger from idle; readback 1 cycle.
// Backpressure: none; triggers during a rebuild are folded into one pending restart.
module a8_aperture_regs #(
    parameter int           NUM_AP   = 4,
    parameter logic [255:0] BASE_MAP = 256'h40
) (
    input  logic         clk200,
    input  logic         a8_rst,
    input  logic         wr_stb,
    input  logic [7:0]   wr_addr,
    input  logic [7:0]   wr_data,
    input  logic [7:0]   rd_addr,
    output logic [7:0]   rd_data,
    output logic [255:0] page_map,
    output logic         busy
);
    import pixl_ap_pkg::*;

    localparam logic [4:0] NUM_AP_L = 5'(NUM_AP);
    localparam logic [3:0] LAST_IDX = 4'(NUM_AP - 1);

    // Full 16-aperture address space; entries above NUM_AP are never written
    logic [7:0]   regs [256];

    ap_state_t    state, state_nxt;
    logic [3:0]   idx;
    logic [255:0] shadow;
    logic         pending;

    logic         wr_ok;
    logic         trig;
    logic         restart;
    logic         commit;
    logic         pend_clr;

    logic [7:0]   scan_start;
    logic [7:0]   scan_count;
    logic         scan_en;
    logic [255:0] scan_mask;

    assign wr_ok = wr_stb && ({1'b0, wr_addr[7:4]} < NUM_AP_L);
    assign trig  = wr_ok && ((wr_addr[3:0] == AP_OFS_START) ||
                             (wr_addr[3:0] == AP_OFS_COUNT) ||
                             (wr_addr[3:0] == AP_OFS_CTRL));

    assign scan_start = regs[{idx, AP_OFS_START}];
    assign scan_count = regs[{idx, AP_OFS_COUNT}];
    assign scan_en    = regs[{idx, AP_OFS_CTRL}][0];

    ap_range_mask u_mask (
        .start (scan_start),
        .count (scan_count),
        .mask  (scan_mask)
    );

    // Descriptor byte storage; out-of-range apertures are dropped
    always_ff @(posedge clk200) begin
        if (a8_rst) begin
            for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Sequencer state register
    always_ff @(posedge clk200) begin
        if (a8_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and control strobes for the rebuild
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        commit    = 1'b0;
        pend_clr  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (trig) begin
                    state_nxt = SCAN;
                    restart   = 1'b1;
                end
            end
            SCAN: begin
                if (idx == LAST_IDX) state_nxt = COMMIT;
            end
            COMMIT: begin
                commit = 1'b1;
                if (pending || trig) begin
                    state_nxt = SCAN;
                    restart   = 1'b1;
                    pend_clr  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy      = 1'b0;
            end
        endcase
    end

    // Shadow accumulation and single-cycle publish of page_map
    always_ff @(posedge clk200) begin
        if (a8_rst) begin
            idx      <= 4'd0;
            shadow   <= BASE_MAP;
            page_map <= BASE_MAP;
        end else begin
            if (restart) begin
                idx    <= 4'd0;
                shadow <= BASE_MAP;
            end else if (state == SCAN) begin
                idx    <= idx + 4'd1;
                shadow <= shadow | (scan_en ? scan_mask : 256'd0);
            end
            if (commit) page_map <= shadow;
        end
    end

    // Remember triggers that arrive while a rebuild is already running
    always_ff @(posedge clk200) begin
        if (a8_rst)                       pending <= 1'b0;
        else if (pend_clr)                pending <= 1'b0;
        else if (trig && state != IDLE)   pending <= 1'b1;
    end

`ifdef A8_AP_READBACK_EN
    // Registered readback; a same-cycle write to the byte returns the old value
    always_ff @(posedge clk200) begin
        if (a8_rst)                                    rd_data <= 8'h00;
        else if ({1'b0, rd_addr[7:4]} < NUM_AP_L)      rd_data <= regs[rd_addr];
        else                                           rd_data <= 8'h00;
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = 8'h00;
`endif

endmodule

// File: tb/tb_a8_aperture_regs.sv
// Purpose: self-checking bench for a8_aperture_regs against a page-range reference model.
// Latency: checks page_map settles within NUM_AP+2 cycles of an idle trigger.
// Backpressure: n/a.
module tb_a8_aperture_regs;

    localparam int           NUM_AP = 4;
    localparam logic [255:0] BASE   = 256'h40;

    logic         clk200 = 1'b0;
    logic         a8_rst;
    logic         wr_stb;
    logic [7:0]   wr_addr;
    logic [7:0]   wr_data;
    logic [7:0]   rd_addr;
    logic [7:0]   rd_data;
    logic [255:0] page_map;
    logic         busy;

    logic [7:0]   mem [256];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic         mon_en = 1'b0;
    logic [255:0] allowed [$];

    a8_aperture_regs #(.NUM_AP(NUM_AP), .BASE_MAP(BASE)) dut (
        .clk200   (clk200),
        .a8_rst   (a8_rst),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .page_map (page_map),
        .busy     (busy)
    );

    always #5 clk200 = ~clk200;

    // Reference: union of enabled [start, start+count) ranges, stopping at page 255
    function automatic logic [255:0] model_map();
        logic [255:0] m;
        int s, c;
        m = BASE;
        for (int ap = 0; ap < NUM_AP; ap++) begin
            if (mem[ap*16 + 15][0]) begin
                s = int'(mem[ap*16 + 4]);
                c = int'(mem[ap*16 + 5]);
                for (int p = s; p < s + c && p < 256; p++) m[p] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [255:0] range_map(input int lo, input int hi);
        logic [255:0] m;
        m = BASE;
        for (int p = lo; p < hi; p++) m[p] = 1'b1;
        return m;
    endfunction

    function automatic logic [7:0] exp_rd(input logic [7:0] a);
`ifdef A8_AP_READBACK_EN
        if (int'(a[7:4]) < NUM_AP) return mem[a];
        return 8'h00;
`else
        return (a == 8'h00) ? 8'h00 : 8'h00;
`endif
    endfunction

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_addr = a;
        wr_data = d;
        wr_stb  = 1'b1;
        @(posedge clk200);
        #1;
        wr_stb  = 1'b0;
        if (int'(a[7:4]) < NUM_AP) mem[a] = d;
    endtask

    task automatic settle(input string name, input int budget);
        logic [255:0] e;
        int k;
        e = model_map();
        k = 0;
        while (k < budget && !(page_map === e && busy === 1'b0)) begin
            @(posedge clk200);
            #1;
            k++;
        end
        n_cmp++;
        if (page_map !== e) begin
            n_bad++;
            $display("FAIL %s page_map got %h want %h", name, page_map, e);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy got %b want 0", name, busy);
        end
    endtask

    task automatic rd_check(input string name, input logic [7:0] a);
        rd_addr = a;
        @(posedge clk200);
        #1;
        n_cmp++;
        if (rd_data !== exp_rd(a)) begin
            n_bad++;
            $display("FAIL %s rd[%h] got %h want %h", name, a, rd_data, exp_rd(a));
        end
    endtask

    // During the busy test every published map must be a whole register snapshot
    always @(negedge clk200) begin
        if (mon_en) begin
            logic hit;
            hit = 1'b0;
            foreach (allowed[i]) if (page_map === allowed[i]) hit = 1'b1;
            n_cmp++;
            if (!hit) begin
                n_bad++;
                $display("FAIL busy_mixed page_map got %h not a snapshot", page_map);
            end
        end
    end

    task automatic test_reset;
        a8_rst = 1'b1;
        repeat (2) @(posedge clk200);
        #1;
        n_cmp++;
        if (page_map !== BASE) begin n_bad++; $display("FAIL reset_map got %h want %h", page_map, BASE); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++;
        if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd got %h want 00", rd_data); end
        a8_rst = 1'b0;
    endtask

    task automatic test_basic_map;
        wr(8'h04, 8'h40); settle("basic_start", NUM_AP + 2);
        wr(8'h05, 8'h10); settle("basic_count", NUM_AP + 2);
        wr(8'h0F, 8'h01); settle("basic_enable", NUM_AP + 2);
        n_cmp++;
        if (page_map !== range_map(8'h40, 8'h50)) begin
            n_bad++;
            $display("FAIL basic_const got %h want %h", page_map, range_map(8'h40, 8'h50));
        end
        rd_check("basic_rd05", 8'h05);
    endtask

    task automatic test_clamp;
        logic [7:0] top;
        wr(8'h14, 8'hF8); settle("clamp_start", NUM_AP + 2);
        wr(8'h15, 8'h20); settle("clamp_count", NUM_AP + 2);
        wr(8'h1F, 8'h01); settle("clamp_enable", NUM_AP + 2);
        top = page_map[255:248];
        n_cmp++;
        if (top !== 8'hFF) begin n_bad++; $display("FAIL clamp_top got %h want ff", top); end
        n_cmp++;
        if (page_map[0] !== 1'b0) begin n_bad++; $display("FAIL clamp_nowrap bit0 got %b want 0", page_map[0]); end
        wr(8'h15, 8'h00); settle("clamp_zero", NUM_AP + 2);
        n_cmp++;
        if (page_map !== range_map(8'h40, 8'h50)) begin
            n_bad++;
            $display("FAIL clamp_zero_const got %h want %h", page_map, range_map(8'h40, 8'h50));
        end
    endtask

    task automatic test_busy_write;
        allowed.delete();
        allowed.push_back(page_map);
        allowed.push_back(range_map(8'h40, 8'h50));
        allowed.push_back(range_map(8'h40, 8'h44));
        mon_en = 1'b1;
        wr(8'h05, 8'h10);
        @(posedge clk200);
        #1;
        wr(8'h05, 8'h04);
        settle("busy_final", 3 * NUM_AP + 4);
        mon_en = 1'b0;
        n_cmp++;
        if (page_map !== range_map(8'h40, 8'h44)) begin
            n_bad++;
            $display("FAIL busy_const got %h want %h", page_map, range_map(8'h40, 8'h44));
        end
    endtask

    task automatic test_overlap_oor;
        wr(8'h05, 8'h10); settle("ovl_ap0", NUM_AP + 2);
        wr(8'h14, 8'h48); settle("ovl_ap1_start", NUM_AP + 2);
        wr(8'h15, 8'h18); settle("ovl_ap1_count", NUM_AP + 2);
        n_cmp++;
        if (page_map !== range_map(8'h40, 8'h60)) begin
            n_bad++;
            $display("FAIL ovl_union got %h want %h", page_map, range_map(8'h40, 8'h60));
        end
        wr(8'h0F, 8'h00); settle("ovl_disable", NUM_AP + 2);
        n_cmp++;
        if (page_map !== range_map(8'h48, 8'h60)) begin
            n_bad++;
            $display("FAIL ovl_remain got %h want %h", page_map, range_map(8'h48, 8'h60));
        end
        wr(8'h40, 8'hAA);
        wr(8'h44, 8'h10);
        wr(8'h4F, 8'h01);
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL oor_busy got %b want 0", busy); end
        settle("oor_map", NUM_AP + 2);
        rd_check("oor_rd40", 8'h40);
        rd_check("oor_rd4f", 8'h4F);
    endtask

    task automatic test_random;
        logic [3:0] ofs_tab [4];
        logic [7:0] a, d;
        int sel;
        ofs_tab[0] = 4'h4; ofs_tab[1] = 4'h5; ofs_tab[2] = 4'hF; ofs_tab[3] = 4'h0;
        for (int it = 0; it < 30; it++) begin
            sel = $urandom_range(0, 3);
            a[7:4] = 4'($urandom_range(0, NUM_AP + 1));
            a[3:0] = (sel == 3) ? 4'($urandom_range(0, 15)) : ofs_tab[sel];
            d = 8'($urandom);
            wr(a, d);
            settle("rand_single", NUM_AP + 2);
            rd_check("rand_rd", 8'($urandom_range(0, 16 * (NUM_AP + 1) - 1)));
        end
        for (int it = 0; it < 8; it++) begin
            sel = $urandom_range(0, 2);
            a[7:4] = 4'($urandom_range(0, NUM_AP - 1));
            a[3:0] = ofs_tab[sel];
            wr(a, 8'($urandom));
        end
        settle("rand_burst", 4 * NUM_AP + 8);
    endtask

    task automatic test_reset_mid;
        wr(8'h04, 8'h40); wr(8'h05, 8'h10); wr(8'h0F, 8'h01);
        settle("mid_setup", 4 * NUM_AP + 8);
        wr(8'h05, 8'h20);
        @(posedge clk200);
        #1;
        a8_rst = 1'b1;
        @(posedge clk200);
        #1;
        a8_rst = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        n_cmp++;
        if (page_map !== BASE) begin n_bad++; $display("FAIL mid_map got %h want %h", page_map, BASE); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", busy); end
        for (int i = 0; i < 16 * NUM_AP; i += 5) rd_check("mid_rd", 8'(i));
        rd_check("mid_rd_last", 8'(16 * NUM_AP - 1));
        settle("mid_after", NUM_AP + 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        a8_rst  = 1'b1;
        wr_stb  = 1'b0;
        wr_addr = 8'h00;
        wr_data = 8'h00;
        rd_addr = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset;
        test_basic_map;
        test_clamp;
        test_busy_write;
        test_overlap_oor;
        test_random;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
